counter: RTL and testbench

COUNTER -- requirements
Module: counter

---
 rtl/counter_pkg.sv | 6 +
 rtl/counter.sv | 35 +++
 tb/tb_counter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared constants for the terminal-count tick generator.
package counter_pkg;

  localparam int COUNTER_DEFAULT_WIDTH = 27;

endpackage

// File: rtl/counter.sv
// Terminal-count tick generator: ready pulses for one cycle every limit+1 cycles.
// Latency: first pulse limit+1 cycles after reset release; no backpressure, free-running.
module counter
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count_to,
  output logic             ready
);

  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic             at_limit;

  assign at_limit = (count == limit);

  // Wrapping on equality keeps count bounded by limit, so all-ones never overflows.
  always_ff @(posedge clk) begin
    if (reset) begin
      limit <= count_to;
      count <= '0;
      ready <= 1'b0;
    end else if (at_limit) begin
      count <= '0;
      ready <= 1'b1;
    end else begin
      count <= count + WIDTH'(1);
      ready <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter.sv
// Randomized self-checking bench for counter, comparing ready against a period model.
module tb_counter;

  localparam int W  = 27;
  localparam int W4 = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  count_to;
  logic          ready;
  logic          reset4;
  logic [W4-1:0] count_to4;
  logic          ready4;

  int checks = 0;
  int errors = 0;
  string phase = "init";

  // Reference model: after release, ready is expected in every cycle t with t % (limit+1) == 0.
  longint lim, t, lim4, t4;
  bit     exp_ready, exp_ready4;
  bit     armed = 1'b0, armed4 = 1'b0;

  counter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .count_to(count_to), .ready(ready)
  );

  counter #(.WIDTH(W4)) dut4 (
    .clk(clk), .reset(reset4), .count_to(count_to4), .ready(ready4)
  );

  always #1 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s/%s @%0t: got %b expected %b", phase, tag, $time, got, exp);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      lim = longint'(count_to); t = 0; exp_ready = 1'b0; armed = 1'b1;
    end else begin
      t++;
      exp_ready = ((t % (lim + 1)) == 0);
    end
    if (reset4) begin
      lim4 = longint'(count_to4); t4 = 0; exp_ready4 = 1'b0; armed4 = 1'b1;
    end else begin
      t4++;
      exp_ready4 = ((t4 % (lim4 + 1)) == 0);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      if (armed)  chk("ready", ready, exp_ready);
      if (armed4) chk("ready_w4", ready4, exp_ready4);
    end
  endtask

  task automatic do_reset(input logic [W-1:0] ct, input int cycles);
    reset    = 1'b1;
    count_to = ct;
    step(cycles);
    reset    = 1'b0;
  endtask

  int pulses;

  initial begin
    reset = 1'b0; count_to = '0; reset4 = 1'b0; count_to4 = '0;
    @(negedge clk);

    // Period of 16 from count_to=15; the 4-bit instance runs all-ones from here on.
    phase = "period16";
    reset4 = 1'b1; count_to4 = 4'hF;
    do_reset(W'(15), 1);
    reset4 = 1'b0; count_to4 = 4'h3;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (ready) pulses++;
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL %s/pulse_count: got %0d expected 2", phase, pulses);
    end

    phase = "abort_mid";
    step(7);
    do_reset(W'(5), 1);
    step(20);

    phase = "limit0";
    do_reset(W'(0), 1);
    step(10);

    phase = "count_to_ignored";
    do_reset(W'(15), 1);
    count_to = W'(3);
    step(40);

    phase = "reset_held";
    reset = 1'b1;
    count_to = W'(7); step(1);
    count_to = W'(8); step(1);
    count_to = W'(9); step(3);
    reset = 1'b0;
    step(25);

    phase = "random";
    for (int it = 0; it < 60; it++) begin
      do_reset(W'($urandom_range(0, 20)), $urandom_range(1, 3));
      for (int j = 0; j < int'($urandom_range(1, 4)); j++) begin
        step($urandom_range(1, 25));
        if ($urandom_range(0, 1) == 1) count_to = W'($urandom_range(0, 31));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
